ts4231_pulse_timestamper: RTL and testbench
===========================================

Name: ts4231_pulse_timestamper

Overview:
- Sits directly downstream of the TS4231 configurator on the envelope (E) line of sensor 0.
- Once the configurator reports `configured`, it timestamps each lighthouse light pulse against a free-running 96 MHz counter and measures the pulse width.
- It drops short glitches and buffers accepted pulses in a small FIFO.
- It presents the pulses to the sweep/decoder logic over a valid/ready interface.

Parameters:
- TS_WIDTH, 24, width of the free-running timestamp counter; wraps modulo 2^TS_WIDTH.
- PW_WIDTH, 16, width of the pulse-width counter; saturates at all-ones.
- MIN_PULSE, 8, minimum width in clk cycles for a pulse to be recorded.
- FIFO_DEPTH, 4, number of buffered pulse records; must be a power of two, at least 2.
- ACTIVE_LEVEL, 0, E-line level that means "light present".

Ports:
- clk_96MHz  input  1  system clock, 96 MHz
- reset  input  1  asynchronous, active-high reset
- configured  input  1  from the configurator; high means the E line carries valid envelope data
- e_in  input  1  raw E pin level; asynchronous to clk
- pulse_valid  output  1  FIFO head record is available
- pulse_ready  input  1  consumer accepts the head record this cycle
- pulse_timestamp  output  TS_WIDTH  timestamp of the pulse start (FIFO head)
- pulse_width  output  PW_WIDTH  pulse width in clk cycles (FIFO head)
- overflow_count  output  8  qualified pulses dropped because the FIFO was full; saturates at 255
- busy  output  1  high while state is IN_PULSE

Behaviour:
- Reset (async assert, sync deassert by the user): all outputs are 0; FIFO is empty; timestamp counter is 0; state is DISABLED; synchronizer flops are loaded with the inactive level (~ACTIVE_LEVEL).
- Synchronizer: e_in passes through 2 flops to give e_sync. act = (e_sync == ACTIVE_LEVEL). All edge logic uses only e_sync, so pin-to-act latency is 2 cycles.
- Timestamp counter: increments every cycle after reset, independent of `configured`, and wraps from 2^TS_WIDTH-1 to 0.
- State DISABLED: entered from reset, or from any state when configured = 0.
  - On entry the FIFO is flushed, any pulse in progress is abandoned, and overflow_count is held (not cleared).
  - Leaves to WAIT_IDLE when configured = 1.
- State WAIT_IDLE: waits until act = 0, then goes to ARMED. This prevents capturing a pulse already in progress at enable.
- State ARMED: in the first cycle with act = 1:
  - latch ts_start = the counter value in that same cycle;
  - set width = 1;
  - go to IN_PULSE.
- State IN_PULSE:
  - Each cycle with act = 1: width increments, saturating at 2^PW_WIDTH-1.
  - First cycle with act = 0: this is the pulse end; go to ARMED in the same cycle.
  - At pulse end, if width < MIN_PULSE: discard, no FIFO write, overflow_count unchanged.
  - At pulse end, if width >= MIN_PULSE and FIFO is not full: write {ts_start, width}.
  - At pulse end, if width >= MIN_PULSE and FIFO is full: drop the record; overflow_count += 1, saturating.
  - "Full" is evaluated before any same-cycle pop. A pop in the same cycle does not make room.
- Width: equals the number of cycles with act = 1, i.e. the pin-level pulse length, quantised to clk.
- FIFO and interface:
  - A write makes pulse_valid = 1 on the next cycle; if the FIFO was empty, the record appears the cycle after the pulse-end cycle.
  - A pop occurs when pulse_valid && pulse_ready.
  - Simultaneous push and pop with the FIFO not full: both succeed and the count is unchanged.
  - pulse_timestamp and pulse_width are stable while pulse_valid = 1 and pulse_ready = 0.
  - When pulse_valid = 0 they hold their last value; the bench must not check them then.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Records leave in pulse order.
- Mid-operation reset: asserting reset in any state returns the block immediately to the reset values above. Partial pulses are lost.
- Counter wrap during a pulse has no effect on width; ts_start is the raw counter value.

Test Plan:
- Reset; configured = 1; e_in idle = 1; drive e_in = 0 for 20 cycles starting when the counter reads 100 at the pin → one record: pulse_timestamp = 102, pulse_width = 20; pulse_valid rises 1 cycle after the synchronized end; busy high for 20 cycles.
- Glitch: e_in = 0 for 5 cycles (MIN_PULSE = 8) → no record, overflow_count = 0. Then a 8-cycle pulse → record with width = 8.
- Enable mid-pulse: e_in = 0 already; raise configured; e_in stays 0 a further 30 cycles, then idles → no record. The next 12-cycle pulse is recorded with width 12.
- Backpressure: pulse_ready = 0; send 6 pulses of widths 10..15 → FIFO holds widths 10..13; overflow_count = 2. Then pulse_ready = 1 → widths 10, 11, 12, 13 delivered in order, one per cycle.
- Drop configured to 0 with 2 records queued and a pulse in progress → pulse_valid = 0 on the next cycle, FIFO empty, busy = 0. Re-enable with the line idle → the next pulse is captured normally.
- Saturation and wrap: TS_WIDTH = 8, PW_WIDTH = 4 build; pulse starting at counter 250 and lasting 40 cycles → pulse_timestamp = 250, pulse_width = 15.

Source files
------------

// File: rtl/ts4231_pulse_timestamper.sv
// TS4231 envelope pulse timestamper.
// Synchronizes the E line and timestamps each qualified light pulse against a
// free-running counter. It also measures the pulse width and queues the
// {start, width} records in a small FIFO. The FIFO is drained over valid/ready.
module ts4231_pulse_timestamper #(
    parameter int   TS_WIDTH     = 24,
    parameter int   PW_WIDTH     = 16,
    parameter int   MIN_PULSE    = 8,
    parameter int   FIFO_DEPTH   = 4,
    parameter logic ACTIVE_LEVEL = 1'b0
) (
    input  logic                clk_96MHz,
    input  logic                reset,
    input  logic                configured,
    input  logic                e_in,
    output logic                pulse_valid,
    input  logic                pulse_ready,
    output logic [TS_WIDTH-1:0] pulse_timestamp,
    output logic [PW_WIDTH-1:0] pulse_width,
    output logic [7:0]          overflow_count,
    output logic                busy
);

    localparam int                PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PW_WIDTH-1:0] MIN_PW  = PW_WIDTH'(MIN_PULSE);

    typedef enum logic [1:0] {
        DISABLED,
        WAIT_IDLE,
        ARMED,
        IN_PULSE
    } state_t;

    // Synchronizer and timestamp counter
    logic                sync1_reg;
    logic                e_sync_reg;
    logic                act;
    logic [TS_WIDTH-1:0] ts_reg;

    // Pulse tracking
    state_t              state_reg, state_next;
    logic [TS_WIDTH-1:0] ts_start_reg, ts_start_next;
    logic [PW_WIDTH-1:0] pw_reg, pw_next;
    logic                pulse_end;
    logic                qualified;

    // FIFO
    logic [TS_WIDTH-1:0]   mem_ts [FIFO_DEPTH];
    logic [PW_WIDTH-1:0]   mem_pw [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [FIFO_DEPTH-1:0] wr_en;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  flush;

    logic [7:0] ovf_reg;

    assign act = (e_sync_reg == ACTIVE_LEVEL);

    // Two-flop synchronizer; idles at the dark level so reset never looks like light
    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            sync1_reg  <= ~ACTIVE_LEVEL;
            e_sync_reg <= ~ACTIVE_LEVEL;
        end else begin
            sync1_reg  <= e_in;
            e_sync_reg <= sync1_reg;
        end
    end

    // Free-running timestamp counter, wraps naturally
    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + 1'b1;
        end
    end

    // State and pulse datapath registers
    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            state_reg    <= DISABLED;
            ts_start_reg <= '0;
            pw_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            ts_start_reg <= ts_start_next;
            pw_reg       <= pw_next;
        end
    end

    // Next state and pulse capture; losing configured abandons everything
    always_comb begin
        state_next    = state_reg;
        ts_start_next = ts_start_reg;
        pw_next       = pw_reg;
        pulse_end     = 1'b0;
        if (!configured) begin
            state_next = DISABLED;
        end else begin
            case (state_reg)
                DISABLED: begin
                    state_next = WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    // Do not capture a pulse that was already lit at enable
                    if (!act) begin
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (act) begin
                        ts_start_next = ts_reg;
                        pw_next       = PW_WIDTH'(1);
                        state_next    = IN_PULSE;
                    end
                end
                IN_PULSE: begin
                    if (act) begin
                        if (pw_reg != '1) begin
                            pw_next = pw_reg + 1'b1;
                        end
                    end else begin
                        pulse_end  = 1'b1;
                        state_next = ARMED;
                    end
                end
                default: begin
                    state_next = DISABLED;
                end
            endcase
        end
    end

    // Full is judged on the registered count, so a same-cycle pop never makes room
    assign qualified = pulse_end && (pw_reg >= MIN_PW);
    assign full      = (count_reg == DEPTH_CNT);
    assign push      = qualified && !full;
    assign drop      = qualified && full;
    assign pop       = pulse_valid && pulse_ready;
    assign flush     = !configured;

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // FIFO storage; small enough to live in flops with a direct head read
    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_ts[i] <= '0;
                mem_pw[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_ts[i] <= ts_start_reg;
                    mem_pw[i] <= pw_reg;
                end
            end
        end
    end

    // FIFO pointers and occupancy; flushed while the sensor is unconfigured
    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Saturating count of qualified pulses lost to a full FIFO; kept across disable
    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            ovf_reg <= '0;
        end else if (drop && (ovf_reg != 8'hFF)) begin
            ovf_reg <= ovf_reg + 1'b1;
        end
    end

    assign pulse_valid     = (count_reg != '0);
    assign pulse_timestamp = mem_ts[rd_ptr_reg];
    assign pulse_width     = mem_pw[rd_ptr_reg];
    assign overflow_count  = ovf_reg;
    assign busy            = (state_reg == IN_PULSE);

endmodule

// File: tb/tb_ts4231_pulse_timestamper.sv
// Directed bench for the TS4231 pulse timestamper.
// A default-parameter instance is used for the main checks. A second, narrow
// instance covers width saturation and timestamp wrap.
module tb_ts4231_pulse_timestamper;

    logic        clk_96MHz = 1'b0;
    logic        reset;
    logic        configured;
    logic        e_in;
    logic        pulse_valid;
    logic        pulse_ready;
    logic [23:0] pulse_timestamp;
    logic [15:0] pulse_width;
    logic [7:0]  overflow_count;
    logic        busy;

    logic        e_in2;
    logic        pulse_valid2;
    logic [7:0]  pulse_timestamp2;
    logic [3:0]  pulse_width2;
    logic [7:0]  overflow_count2;
    logic        busy2;

    logic [23:0] tb_ts;

    int n_vec = 0;
    int n_err = 0;
    int exp_ovf = 0;

    typedef struct {
        int low;
        bit rec;
        int width;
    } vec_t;

    vec_t vecs [8];

    always #5 clk_96MHz = ~clk_96MHz;

    ts4231_pulse_timestamper dut (
        .clk_96MHz       (clk_96MHz),
        .reset           (reset),
        .configured      (configured),
        .e_in            (e_in),
        .pulse_valid     (pulse_valid),
        .pulse_ready     (pulse_ready),
        .pulse_timestamp (pulse_timestamp),
        .pulse_width     (pulse_width),
        .overflow_count  (overflow_count),
        .busy            (busy)
    );

    ts4231_pulse_timestamper #(
        .TS_WIDTH (8),
        .PW_WIDTH (4)
    ) dut2 (
        .clk_96MHz       (clk_96MHz),
        .reset           (reset),
        .configured      (1'b1),
        .e_in            (e_in2),
        .pulse_valid     (pulse_valid2),
        .pulse_ready     (1'b0),
        .pulse_timestamp (pulse_timestamp2),
        .pulse_width     (pulse_width2),
        .overflow_count  (overflow_count2),
        .busy            (busy2)
    );

    // Reference cycle counter: counts edges since reset release
    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) tb_ts <= '0;
        else       tb_ts <= tb_ts + 1'b1;
    end

    task automatic tick();
        @(posedge clk_96MHz);
        #1;
    endtask

    task automatic chk(input string name, input longint actual, input longint expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Gap, then a pin-level low pulse of 'low' cycles; returns the start cycle
    task automatic send(input int low, output int start);
        e_in = 1'b1;
        repeat (4) tick();
        start = int'(tb_ts);
        e_in = 1'b0;
        repeat (low) tick();
        e_in = 1'b1;
    endtask

    task automatic pop_one();
        pulse_ready = 1'b1;
        tick();
        pulse_ready = 1'b0;
        chk("pop_empties", pulse_valid, 0);
    endtask

    // One isolated pulse followed by a check of the resulting head record
    task automatic run_vec(input string name, input int low, input bit rec, input int width);
        int start;
        send(low, start);
        repeat (6) tick();
        chk({name, "_valid"}, pulse_valid, rec);
        if (rec) begin
            chk({name, "_width"}, pulse_width, width);
            chk({name, "_ts"}, pulse_timestamp, start + 2);
            pop_one();
        end
        chk({name, "_ovf"}, overflow_count, exp_ovf);
        $display("vec %s: low=%0d rec=%0d width=%0d start=%0d", name, low, rec, width, start);
    endtask

    initial begin
        int valid_at;
        int busy_cnt;
        int st [6];
        int s;
        int guard;

        vecs[0] = '{low: 5,   rec: 1'b0, width: 0};
        vecs[1] = '{low: 8,   rec: 1'b1, width: 8};
        vecs[2] = '{low: 7,   rec: 1'b0, width: 0};
        vecs[3] = '{low: 9,   rec: 1'b1, width: 9};
        vecs[4] = '{low: 1,   rec: 1'b0, width: 0};
        vecs[5] = '{low: 2,   rec: 1'b0, width: 0};
        vecs[6] = '{low: 100, rec: 1'b1, width: 100};
        vecs[7] = '{low: 12,  rec: 1'b1, width: 12};

        reset       = 1'b1;
        configured  = 1'b1;
        e_in        = 1'b1;
        e_in2       = 1'b1;
        pulse_ready = 1'b0;
        repeat (3) @(posedge clk_96MHz);
        #1;
        chk("rst_valid", pulse_valid, 0);
        chk("rst_ts", pulse_timestamp, 0);
        chk("rst_width", pulse_width, 0);
        chk("rst_ovf", overflow_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid2", pulse_valid2, 0);
        reset = 1'b0;

        // Basic capture: pin goes low while the counter reads 100
        guard = 0;
        while (tb_ts != 24'd100 && guard < 1000) begin
            tick();
            guard++;
        end
        chk("wait_ts100", tb_ts, 100);
        e_in = 1'b0;
        valid_at = -1;
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 19) e_in = 1'b1;
            if (busy) busy_cnt++;
            if (pulse_valid && valid_at < 0) valid_at = int'(tb_ts);
        end
        chk("t1_valid_cycle", valid_at, 123);
        chk("t1_busy_cycles", busy_cnt, 20);
        chk("t1_valid", pulse_valid, 1);
        chk("t1_ts", pulse_timestamp, 102);
        chk("t1_width", pulse_width, 20);
        pop_one();
        $display("vec t1: ts=102 width=20");

        // Glitch filter and width table
        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("tbl%0d", i), vecs[i].low, vecs[i].rec, vecs[i].width);
        end

        // Enable while the line is already lit: that pulse must be ignored
        configured = 1'b0;
        repeat (2) tick();
        e_in = 1'b0;
        repeat (3) tick();
        configured = 1'b1;
        repeat (30) tick();
        e_in = 1'b1;
        repeat (6) tick();
        chk("midpulse_valid", pulse_valid, 0);
        chk("midpulse_busy", busy, 0);
        run_vec("after_mid", 12, 1'b1, 12);

        // Backpressure: six pulses into a four-deep FIFO
        for (int k = 0; k < 6; k++) send(10 + k, st[k]);
        repeat (6) tick();
        exp_ovf = 2;
        chk("bp_ovf", overflow_count, exp_ovf);
        chk("bp_valid", pulse_valid, 1);
        chk("bp_head", pulse_width, 10);

        // Pulse ends on the very cycle of a pop from a full FIFO: still dropped
        e_in = 1'b0;
        repeat (9) tick();
        e_in = 1'b1;
        repeat (2) tick();
        pulse_ready = 1'b1;
        tick();
        pulse_ready = 1'b0;
        repeat (3) tick();
        exp_ovf = 3;
        chk("fullpop_ovf", overflow_count, exp_ovf);

        pulse_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("drain%0d_valid", k), pulse_valid, 1);
            chk($sformatf("drain%0d_width", k), pulse_width, 10 + k);
            chk($sformatf("drain%0d_ts", k), pulse_timestamp, st[k] + 2);
            tick();
        end
        pulse_ready = 1'b0;
        chk("drain_empty", pulse_valid, 0);
        $display("vec backpressure: ovf=%0d", overflow_count);

        // Disable with two records queued and a pulse in progress
        send(10, s);
        send(10, s);
        repeat (6) tick();
        chk("dis_queued", pulse_valid, 1);
        e_in = 1'b0;
        repeat (5) tick();
        chk("dis_busy_before", busy, 1);
        configured = 1'b0;
        tick();
        chk("dis_valid", pulse_valid, 0);
        chk("dis_busy", busy, 0);
        repeat (2) tick();
        e_in = 1'b1;
        repeat (3) tick();
        chk("dis_ovf_held", overflow_count, exp_ovf);
        chk("dis_still_empty", pulse_valid, 0);
        configured = 1'b1;
        repeat (4) tick();
        run_vec("reenable", 11, 1'b1, 11);

        // Narrow build: width saturation and counter wrap during the pulse
        guard = 0;
        while (tb_ts[7:0] != 8'd248 && guard < 1000) begin
            tick();
            guard++;
        end
        chk("wait_ts248", tb_ts[7:0], 248);
        e_in2 = 1'b0;
        repeat (40) tick();
        e_in2 = 1'b1;
        repeat (6) tick();
        chk("sat_valid", pulse_valid2, 1);
        chk("sat_ts", pulse_timestamp2, 250);
        chk("sat_width", pulse_width2, 15);
        chk("sat_ovf", overflow_count2, 0);
        chk("sat_busy", busy2, 0);
        $display("vec saturate: ts=%0d width=%0d", pulse_timestamp2, pulse_width2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
